accel_spi_reader: RTL and testbench
===================================

Name: accel_spi_reader

Overview:
- Producer side of the accelerometer data path: an SPI master that configures a 3-axis accelerometer (ADXL345 register map) and periodically burst-reads X/Y/Z.
- Converts each 10-bit two's-complement reading to 10-bit sign-magnitude (bit 9 = sign, bits 8:0 = magnitude) and presents it on x/y/z_accel_data for the complementary-filter block.
- Sits between the board accelerometer pins and the attitude filter.

Parameters:
- CLK_DIV, 50: clk cycles per SCLK half-period; SCLK = clk/(2*CLK_DIV); legal range ≥2.
- SAMPLE_PERIOD, 100000: clk cycles of idle between the end of one read (UPDATE) and the start of the next; legal range ≥1.

Ports:
- clk  input  1  system clock
- RST  input  1  asynchronous, active-high reset
- miso  input  1  SPI data from the sensor
- sclk  output  1  SPI clock, mode 3, idles high
- mosi  output  1  SPI data to the sensor
- cs_n  output  1  SPI chip select, active low
- x_accel_data  output  10  X acceleration, sign-magnitude
- y_accel_data  output  10  Y acceleration, sign-magnitude
- z_accel_data  output  10  Z acceleration, sign-magnitude
- data_valid  output  1  one-clk pulse when new X/Y/Z values appear
- busy  output  1  high while cs_n is low or a configuration/read sequence is in progress

Behaviour:
- Reset (async, RST=1): cs_n=1, sclk=1, mosi=0, x/y/z_accel_data=0, data_valid=0, busy=1, FSM→CFG_FMT, all counters cleared.
- Reset mid-transaction: the frame aborts immediately (cs_n rises, no data update) and configuration restarts after RST is released.
- FSM states: CFG_FMT → GAP1 → CFG_PWR → GAP2 → WAIT → READ → UPDATE → WAIT.
  - CFG_FMT sends a 16-bit write: 0x31, 0x00 (DATA_FORMAT: ±2 g, 10-bit).
  - CFG_PWR sends 0x2D, 0x08 (POWER_CTL: measure).
  - GAPn hold cs_n high for 2*CLK_DIV cycles.
  - WAIT counts SAMPLE_PERIOD cycles, then enters READ. busy=0 only in WAIT.
  - READ sends command 0xF2 (read, multi-byte, address 0x32), then clocks 48 bits in. Total frame = 56 bits; mosi=0 after the command byte.
  - UPDATE lasts one cycle: outputs load and data_valid=1. Next state is WAIT.
- SPI frame timing (N bits):
  - cs_n falls with bit 0 driven on mosi and sclk high.
  - Each bit: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - mosi changes only on the cycle sclk goes low, except bit 0, which is valid from cs_n fall.
  - miso is sampled on the clk edge where sclk goes high.
  - After the last rising edge, cs_n stays low CLK_DIV more cycles, then rises.
  - Frame length = 2*CLK_DIV*N + CLK_DIV cycles of cs_n low. All bytes are sent and received MSB first.
- Data assembly:
  - Received bytes in order: X0, X1, Y0, Y1, Z0, Z1 (little-endian).
  - Raw 10-bit value v = {Hi[1:0], Lo[7:0]}; Hi[7:2] is ignored.
- Conversion:
  - v ≥ 0: output {1'b0, v[8:0]}.
  - v < 0: output {1'b1, (-v)[8:0]}.
  - v = -512 saturates to 10'h3FF.
  - -0 is never produced.
- Outputs hold their value between UPDATE cycles; all three axes change on the same clk edge as the data_valid pulse.
- data_valid is never high in two consecutive cycles.

Test Plan:
- Reset: assert RST mid-simulation → cs_n=1, sclk=1, mosi=0, outputs 0x000, data_valid=0 on the same cycle, before any clk edge.
- Configuration: release reset with CLK_DIV=2 and an SPI slave model → first frame shifts 0x31, 0x00 (16 sclk falling edges); cs_n high ≥4 cycles; second frame shifts 0x2D, 0x08.
- Read frame: SAMPLE_PERIOD=10 → after 10 WAIT cycles, mosi byte 0xF2 with exactly 56 sclk rising edges while cs_n is low; cs_n low for 2*2*56+2=226 cycles.
- Conversion: slave returns X=05 00, Y=FB FF, Z=00 02 → one data_valid pulse with x=10'h005, y=10'h205, z=10'h3FF (saturated −512). Next frame Z=FF 01 → z=10'h1FF.
- Reset during READ: assert RST after 20 bits → cs_n rises at once, outputs retain 0 (no data_valid). After release, the sequence restarts at CFG_FMT (0x31 seen again).
- Periodicity: run 3 reads → data_valid pulses spaced exactly 226+1+10 cycles apart; busy=0 only during the 10 WAIT cycles.

Source files
------------

// File: rtl/accel_spi_reader.sv
// SPI master for an ADXL345-style accelerometer. It configures the sensor
// (DATA_FORMAT, then POWER_CTL), then periodically burst-reads X/Y/Z and
// presents each axis as 10-bit sign-magnitude.
module accel_spi_reader #(
  parameter int CLK_DIV       = 50,
  parameter int SAMPLE_PERIOD = 100000
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic [9:0] x_accel_data,
  output logic [9:0] y_accel_data,
  output logic [9:0] z_accel_data,
  output logic       data_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_CFG_FMT, ST_GAP1, ST_CFG_PWR, ST_GAP2, ST_WAIT, ST_READ, ST_UPDATE
  } state_e;

  typedef enum logic [1:0] {PH_LOW, PH_HIGH, PH_TAIL} phase_e;

  state_e      state_q, state_d;
  phase_e      phase_q;
  logic [31:0] cnt_q;
  logic [5:0]  bit_q;
  logic [15:0] tx_q;
  logic [47:0] rx_q;
  logic [9:0]  x_q, y_q, z_q;
  // Holds off the first CFG_FMT frame for one cycle so cs_n stays high in reset.
  logic        armed_q;

  logic        in_frame;
  logic        div_last;
  logic [5:0]  last_bit;
  logic        frame_done;

  assign in_frame   = armed_q && (state_q inside {ST_CFG_FMT, ST_CFG_PWR, ST_READ});
  assign div_last   = (cnt_q == 32'(CLK_DIV - 1));
  assign last_bit   = (state_q == ST_READ) ? 6'd55 : 6'd15;
  assign frame_done = in_frame && (phase_q == PH_TAIL) && div_last;

  function automatic logic [9:0] to_sign_mag(input logic [9:0] v);
    logic [8:0] mag;
    mag = ~v[8:0] + 9'd1;
    if (!v[9])              return {1'b0, v[8:0]};
    else if (v == 10'h200)  return 10'h3FF;
    else                    return {1'b1, mag};
  endfunction

  // State register.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) state_q <= ST_CFG_FMT;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CFG_FMT: if (frame_done) state_d = ST_GAP1;
      ST_GAP1:    if (cnt_q == 32'(2 * CLK_DIV - 1)) state_d = ST_CFG_PWR;
      ST_CFG_PWR: if (frame_done) state_d = ST_GAP2;
      ST_GAP2:    if (cnt_q == 32'(2 * CLK_DIV - 1)) state_d = ST_WAIT;
      ST_WAIT:    if (cnt_q == 32'(SAMPLE_PERIOD - 1)) state_d = ST_READ;
      ST_READ:    if (frame_done) state_d = ST_UPDATE;
      ST_UPDATE:  state_d = ST_WAIT;
      default:    state_d = ST_CFG_FMT;
    endcase
  end

  // Bit timing, shift registers, and axis capture.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      armed_q <= 1'b0;
      cnt_q   <= '0;
      phase_q <= PH_LOW;
      bit_q   <= '0;
      tx_q    <= 16'h3100;
      rx_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      armed_q <= 1'b1;
      if (state_d != state_q) begin
        cnt_q   <= '0;
        phase_q <= PH_LOW;
        bit_q   <= '0;
        case (state_d)
          ST_CFG_PWR: tx_q <= 16'h2D08;
          ST_READ:    tx_q <= 16'hF200;
          default:    ;
        endcase
      end else if (in_frame) begin
        if (div_last) begin
          cnt_q <= '0;
          case (phase_q)
            PH_LOW: begin
              phase_q <= PH_HIGH;
              rx_q    <= {rx_q[46:0], miso};
            end
            PH_HIGH: begin
              if (bit_q == last_bit) begin
                phase_q <= PH_TAIL;
              end else begin
                phase_q <= PH_LOW;
                bit_q   <= bit_q + 6'd1;
                tx_q    <= {tx_q[14:0], 1'b0};
              end
            end
            default: ;
          endcase
        end else begin
          cnt_q <= cnt_q + 32'd1;
        end
      end else if (armed_q) begin
        cnt_q <= cnt_q + 32'd1;
      end
      // Received order is X0 X1 Y0 Y1 Z0 Z1; the raw value is {Hi[1:0], Lo}.
      if (state_q == ST_READ && state_d == ST_UPDATE) begin
        x_q <= to_sign_mag({rx_q[33:32], rx_q[47:40]});
        y_q <= to_sign_mag({rx_q[17:16], rx_q[31:24]});
        z_q <= to_sign_mag({rx_q[1:0],   rx_q[15:8]});
      end
    end
  end

  // Output decode.
  always_comb begin
    cs_n         = !in_frame;
    sclk         = !(in_frame && phase_q == PH_LOW);
    mosi         = in_frame ? tx_q[15] : 1'b0;
    data_valid   = (state_q == ST_UPDATE);
    busy         = (state_q != ST_WAIT);
    x_accel_data = x_q;
    y_accel_data = y_q;
    z_accel_data = z_q;
  end

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: SPI slave model, frame/data scoreboards.
module tb_accel_spi_reader;

  localparam int CD      = 2;
  localparam int SP      = 10;
  localparam int LEN_CFG = 2 * CD * 16 + CD;
  localparam int LEN_RD  = 2 * CD * 56 + CD;
  localparam int PERIOD  = LEN_RD + 1 + SP;

  logic       clk = 1'b0;
  logic       RST = 1'b0;
  logic       miso = 1'b1;
  logic       sclk, mosi, cs_n, data_valid, busy;
  logic [9:0] x_accel_data, y_accel_data, z_accel_data;

  accel_spi_reader #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP)) dut (
    .clk(clk), .RST(RST), .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .x_accel_data(x_accel_data), .y_accel_data(y_accel_data),
    .z_accel_data(z_accel_data), .data_valid(data_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int nbits; logic [55:0] bits; int len; } frame_t;
  typedef struct { logic [9:0] x, y, z; } data_t;
  frame_t exp_f[$];
  data_t  exp_d[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_frame(input int n, input logic [55:0] b, input int l);
    frame_t f;
    f.nbits = n; f.bits = b; f.len = l;
    exp_f.push_back(f);
  endtask

  task automatic push_data(input logic [9:0] x, input logic [9:0] y, input logic [9:0] z);
    data_t d;
    d.x = x; d.y = y; d.z = z;
    exp_d.push_back(d);
  endtask

  // SPI slave: shifts out {dummy byte, payload} MSB first, changing on sclk fall.
  logic [55:0] payload_word = '0;
  logic [55:0] mosi_sr = '0;
  int s_idx = 0;
  int nbits = 0;
  int low_cnt = 0;
  int high_cnt = 0;
  bit gap_valid = 0;

  always @(negedge sclk) begin
    #1;
    if (!cs_n && !RST && s_idx < 56) begin
      miso = payload_word[55 - s_idx];
      s_idx++;
    end
  end

  always @(posedge sclk) begin
    if (!cs_n) begin
      mosi_sr = {mosi_sr[54:0], mosi};
      nbits++;
    end
  end

  always @(negedge cs_n) begin
    if (gap_valid) check("cs_gap_ge4", 64'(high_cnt >= 2 * CD), 64'd1);
    s_idx = 0; nbits = 0; mosi_sr = '0; low_cnt = 0; high_cnt = 0;
  end

  always @(posedge RST) gap_valid = 0;

  // Frame monitor.
  always @(posedge cs_n) begin
    frame_t e;
    if (RST) begin
      gap_valid = 0;
    end else begin
      if (exp_f.size() == 0) begin
        tests++; fails++;
        $display("FAIL frame_unexpected: got frame of %0d bits, expected none", nbits);
      end else begin
        e = exp_f.pop_front();
        check("frame_bits", 64'(nbits), 64'(e.nbits));
        check("frame_mosi", 64'(mosi_sr), 64'(e.bits));
        check("frame_len",  64'(low_cnt), 64'(e.len));
      end
      gap_valid = 1;
      high_cnt = 0;
    end
  end

  // Data monitor and timing counters.
  int  dv_count = 0;
  int  cyc_since = 0;
  int  busy_low = 0;
  bit  have_prev = 0;
  bit  prev_dv = 0;

  always @(negedge clk) begin
    data_t d;
    if (!cs_n) low_cnt++; else high_cnt++;
    if (RST) begin
      have_prev = 0; busy_low = 0; prev_dv = 0; cyc_since = 0;
    end else begin
      cyc_since++;
      if (!busy) busy_low++;
      if (data_valid) begin
        check("dv_single", 64'(prev_dv), 64'd0);
        if (exp_d.size() == 0) begin
          tests++; fails++;
          $display("FAIL dv_unexpected: got x=%h y=%h z=%h, expected no pulse",
                   x_accel_data, y_accel_data, z_accel_data);
        end else begin
          d = exp_d.pop_front();
          check("x_data", 64'(x_accel_data), 64'(d.x));
          check("y_data", 64'(y_accel_data), 64'(d.y));
          check("z_data", 64'(z_accel_data), 64'(d.z));
        end
        if (have_prev) check("dv_spacing", 64'(cyc_since), 64'(PERIOD));
        check("wait_cycles", 64'(busy_low), 64'(SP));
        have_prev = 1; cyc_since = 0; busy_low = 0;
        dv_count++;
      end
      prev_dv = data_valid;
    end
  end

  task automatic wait_dv(input int budget);
    int start;
    start = dv_count;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dv_count > start) return;
    end
    tests++; fails++;
    $display("FAIL dv_timeout: got no data_valid in %0d cycles, expected a pulse", budget);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"}, 64'(cs_n), 64'd1);
    check({tag, "_sclk"}, 64'(sclk), 64'd1);
    check({tag, "_mosi"}, 64'(mosi), 64'd0);
    check({tag, "_x"},    64'(x_accel_data), 64'd0);
    check({tag, "_y"},    64'(y_accel_data), 64'd0);
    check({tag, "_z"},    64'(z_accel_data), 64'd0);
    check({tag, "_dv"},   64'(data_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd1);
  endtask

  initial begin : stim
    int dv_before;
    bit seen;
    #1 RST = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por");

    // X=05 00 -> 005, Y=FB FF -> -5 -> 205, Z=00 02 -> -512 -> 3FF.
    payload_word = {8'h00, 48'h0500_FBFF_0002};
    push_frame(16, 56'h3100, LEN_CFG);
    push_frame(16, 56'h2D08, LEN_CFG);
    push_frame(56, 56'hF2_0000_0000_0000, LEN_RD);
    push_data(10'h005, 10'h205, 10'h3FF);
    @(negedge clk) RST = 1'b0;
    wait_dv(2000);

    // Z=FF 01 -> +511 -> 1FF.
    payload_word = {8'h00, 48'h0500_FBFF_FF01};
    push_frame(56, 56'hF2_0000_0000_0000, LEN_RD);
    push_data(10'h005, 10'h205, 10'h1FF);
    wait_dv(400);

    // X=FF FF -> -1 -> 201 (Hi[7:2] ignored), Y=FF 01 -> 1FF, Z=80 03 -> -128 -> 280.
    payload_word = {8'h00, 48'hFFFF_FF01_8003};
    push_frame(56, 56'hF2_0000_0000_0000, LEN_RD);
    push_data(10'h201, 10'h1FF, 10'h280);
    wait_dv(400);

    // Abort the next read after 20 bits.
    payload_word = {8'h00, 48'h1234_5678_9ABC};
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (!cs_n) seen = 1;
    end
    check("read_started", 64'(seen), 64'd1);
    repeat (20 * 2 * CD) @(posedge clk);
    dv_before = dv_count;
    @(negedge clk);
    #1 RST = 1'b1;
    #1 check_reset_outputs("mid");
    repeat (3) @(posedge clk);
    push_frame(16, 56'h3100, LEN_CFG);
    push_frame(16, 56'h2D08, LEN_CFG);
    @(negedge clk) RST = 1'b0;
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (exp_f.size() == 0) seen = 1;
    end
    check("reconfig_done", 64'(seen), 64'd1);
    check("no_dv_after_abort", 64'(dv_count), 64'(dv_before));
    check("x_held_zero", 64'(x_accel_data), 64'd0);
    check("data_queue_empty", 64'(exp_d.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
